// File: rtl/sram_like_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_like_arbiter_if
// Bundles the three SRAM-like interfaces that meet at the arbiter:
//   inst_*  : instruction-fetch requester (req/addr in, addr_ok/data_ok/rdata out)
//   data_*  : EX/MEM load/store requester (req/wr/size/wstrb/addr/wdata in,
//             addr_ok/data_ok/rdata out)
//   bus_*   : shared bus toward the CPU bridge (muxed request out,
//             addr_ok/data_ok/rdata back)
//   ot_count / proto_err : status outputs of the arbiter
// Modport "slave" is the arbiter's view; "master" is the surrounding logic
// (stages + bridge) that drives the requests and the bus responses.
// ---------------------------------------------------------------------------
interface sram_like_arbiter_if #(
    parameter int AW       = 32,
    parameter int OT_DEPTH = 4
);
    localparam int CW = $clog2(OT_DEPTH) + 1;

    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [31:0]   inst_rdata;

    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [3:0]    data_wstrb;
    logic [AW-1:0] data_addr;
    logic [31:0]   data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [31:0]   data_rdata;

    logic          bus_req;
    logic          bus_wr;
    logic [1:0]    bus_size;
    logic [3:0]    bus_wstrb;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_addr_ok;
    logic          bus_data_ok;
    logic [31:0]   bus_rdata;

    logic [CW-1:0] ot_count;
    logic          proto_err;

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        output ot_count, proto_err
    );

    modport master (
        output inst_req, inst_addr,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        input  ot_count, proto_err
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// ---------------------------------------------------------------------------
// sram_like_arbiter
// Shares one SRAM-like bus between instruction fetch and the data port.
// Round-robin grant on contention, grant held (locked) until bus_addr_ok,
// and an order FIFO of OT_DEPTH source bits routes the strictly in-order
// bus responses back to whichever requester issued them.
// Ports:
//   clk     : clock, rising edge
//   resetn  : asynchronous active-low reset
//   arb     : sram_like_arbiter_if.slave (requesters, bus, status)
// ---------------------------------------------------------------------------
module sram_like_arbiter #(
    parameter int OT_DEPTH = 4,
    parameter int AW       = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    sram_like_arbiter_if.slave   arb
);
    localparam int PW = $clog2(OT_DEPTH);
    localparam int CW = PW + 1;
    localparam logic SRC_I = 1'b0;
    localparam logic SRC_D = 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOCK_I, ST_LOCK_D} state_t;

    state_t          state_q;
    logic [OT_DEPTH-1:0] fifo_q;
    logic [OT_DEPTH-1:0] fifo_we;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_src_q;
    logic            proto_err_q;

    logic            fifo_full, fifo_empty;
    logic            grant_vld, grant_src, grant_req;
    logic            bus_req_w, push, pop, head_src;

    assign fifo_full  = (cnt_q == CW'(OT_DEPTH));
    assign fifo_empty = (cnt_q == '0);

    // Grant selection. A locked source stays muxed even if the FIFO has
    // since become non-full or the other side is requesting.
    always_comb begin
        grant_vld = 1'b0;
        grant_src = SRC_I;
        case (state_q)
            ST_LOCK_I: begin grant_vld = 1'b1; grant_src = SRC_I; end
            ST_LOCK_D: begin grant_vld = 1'b1; grant_src = SRC_D; end
            default: begin
                // Full blocks new grants even when a pop lands this cycle.
                if (!fifo_full) begin
                    if (arb.inst_req && arb.data_req) begin
                        grant_vld = 1'b1;
                        grant_src = ~last_src_q;
                    end else if (arb.inst_req) begin
                        grant_vld = 1'b1;
                        grant_src = SRC_I;
                    end else if (arb.data_req) begin
                        grant_vld = 1'b1;
                        grant_src = SRC_D;
                    end
                end
            end
        endcase
    end

    assign grant_req = grant_src ? arb.data_req : arb.inst_req;
    assign bus_req_w = grant_vld & grant_req;
    assign push      = bus_req_w & arb.bus_addr_ok;
    assign head_src  = fifo_q[rd_ptr_q];
    assign pop       = arb.bus_data_ok & ~fifo_empty;

    assign arb.bus_req   = bus_req_w;
    assign arb.bus_wr    = grant_src ? arb.data_wr    : 1'b0;
    assign arb.bus_size  = grant_src ? arb.data_size  : 2'd2;
    assign arb.bus_wstrb = grant_src ? arb.data_wstrb : 4'h0;
    assign arb.bus_addr  = grant_src ? arb.data_addr  : arb.inst_addr;
    assign arb.bus_wdata = grant_src ? arb.data_wdata : 32'h0;

    assign arb.inst_addr_ok = push & (grant_src == SRC_I);
    assign arb.data_addr_ok = push & (grant_src == SRC_D);
    assign arb.inst_data_ok = pop & (head_src == SRC_I);
    assign arb.data_data_ok = pop & (head_src == SRC_D);
    assign arb.inst_rdata   = arb.bus_rdata;
    assign arb.data_rdata   = arb.bus_rdata;
    assign arb.ot_count     = cnt_q;
    assign arb.proto_err    = proto_err_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Per-entry write enables for the order FIFO.
    for (genvar gi = 0; gi < OT_DEPTH; gi++) begin : g_we
        assign fifo_we[gi] = push && (wr_ptr_q == PW'(gi));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fifo_q <= '0;
        end else begin
            for (int i = 0; i < OT_DEPTH; i++) begin
                if (fifo_we[i]) fifo_q[i] <= grant_src;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            last_src_q  <= SRC_I;
            proto_err_q <= 1'b0;
        end else begin
            // Pointers wrap naturally since OT_DEPTH is a power of two.
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + PW'(1);
                last_src_q <= grant_src;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_d;
            if (arb.bus_data_ok && fifo_empty) proto_err_q <= 1'b1;
        end
    end

    // Grant FSM: lock the granted source until its address is accepted,
    // or release it if the requester withdraws (no push in that case).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_LOCK_I, ST_LOCK_D: begin
                    if (!grant_req || arb.bus_addr_ok) state_q <= ST_IDLE;
                end
                default: begin
                    if (grant_vld && !arb.bus_addr_ok)
                        state_q <= grant_src ? ST_LOCK_D : ST_LOCK_I;
                    else
                        state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;
    localparam logic [31:0] INST_ADDR = 32'h0000_0100;
    localparam logic [31:0] DATA_ADDR = 32'h0000_1000;
    localparam logic [31:0] DATA_WDAT = 32'h1234_5678;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    sram_like_arbiter_if #(.AW(32), .OT_DEPTH(4)) u_if ();

    sram_like_arbiter #(.OT_DEPTH(4), .AW(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .arb    (u_if.slave)
    );

    typedef struct packed {
        logic        ir, dr, aok, dok;
        logic [31:0] rd;
        logic        e_iaok, e_daok, e_breq, e_sel;
        logic [2:0]  e_cnt;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    logic sb_q[$];          // expected response order (0 = inst, 1 = data)
    logic proto_model = 1'b0;
    vec_t vecs[$];

    function automatic vec_t v(int ir, int dr, int aok, int dok, logic [31:0] rd,
                               int eia, int eda, int ebr, int esel, int ecnt);
        vec_t r;
        r.ir = 1'(ir); r.dr = 1'(dr); r.aok = 1'(aok); r.dok = 1'(dok);
        r.rd = rd;
        r.e_iaok = 1'(eia); r.e_daok = 1'(eda); r.e_breq = 1'(ebr);
        r.e_sel = 1'(esel); r.e_cnt = 3'(ecnt);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int idx, input vec_t t);
        logic exp_idok, exp_ddok, popped;
        @(negedge clk);
        u_if.inst_req    = t.ir;
        u_if.data_req    = t.dr;
        u_if.bus_addr_ok = t.aok;
        u_if.bus_data_ok = t.dok;
        u_if.bus_rdata   = t.rd;
        #1;
        exp_idok = 1'b0; exp_ddok = 1'b0; popped = 1'b0;
        if (t.dok && sb_q.size() > 0) begin
            popped = 1'b1;
            if (sb_q.pop_front()) exp_ddok = 1'b1; else exp_idok = 1'b1;
        end
        $display("step %0d: ir=%0b dr=%0b aok=%0b dok=%0b -> iaok=%0b daok=%0b breq=%0b idok=%0b ddok=%0b cnt=%0d perr=%0b",
                 idx, t.ir, t.dr, t.aok, t.dok, u_if.inst_addr_ok, u_if.data_addr_ok,
                 u_if.bus_req, u_if.inst_data_ok, u_if.data_data_ok, u_if.ot_count, u_if.proto_err);
        chk("inst_addr_ok", 32'(u_if.inst_addr_ok), 32'(t.e_iaok));
        chk("data_addr_ok", 32'(u_if.data_addr_ok), 32'(t.e_daok));
        chk("bus_req",      32'(u_if.bus_req),      32'(t.e_breq));
        if (t.e_breq) begin
            chk("bus_addr",  u_if.bus_addr,  t.e_sel ? DATA_ADDR : INST_ADDR);
            chk("bus_wstrb", 32'(u_if.bus_wstrb), t.e_sel ? 32'hF : 32'h0);
            chk("bus_wdata", u_if.bus_wdata, t.e_sel ? DATA_WDAT : 32'h0);
        end
        chk("ot_count",     32'(u_if.ot_count),     32'(t.e_cnt));
        chk("inst_data_ok", 32'(u_if.inst_data_ok), 32'(exp_idok));
        chk("data_data_ok", 32'(u_if.data_data_ok), 32'(exp_ddok));
        chk("proto_err",    32'(u_if.proto_err),    32'(proto_model));
        if (popped) begin
            chk("inst_rdata", u_if.inst_rdata, t.rd);
            chk("data_rdata", u_if.data_rdata, t.rd);
        end
        if (t.dok && !popped) proto_model = 1'b1;
        if (t.e_iaok) sb_q.push_back(1'b0);
        if (t.e_daok) sb_q.push_back(1'b1);
    endtask

    initial begin
        u_if.inst_req = 1'b0; u_if.inst_addr = INST_ADDR;
        u_if.data_req = 1'b0; u_if.data_wr = 1'b0; u_if.data_size = 2'd2;
        u_if.data_wstrb = 4'hF; u_if.data_addr = DATA_ADDR; u_if.data_wdata = DATA_WDAT;
        u_if.bus_addr_ok = 1'b0; u_if.bus_data_ok = 1'b1; u_if.bus_rdata = 32'h5A5A_5A5A;

        // Reset state, with a stray bus_data_ok held during reset.
        repeat (2) @(negedge clk);
        #1;
        chk("rst ot_count",     32'(u_if.ot_count),     32'd0);
        chk("rst proto_err",    32'(u_if.proto_err),    32'd0);
        chk("rst inst_data_ok", 32'(u_if.inst_data_ok), 32'd0);
        chk("rst data_data_ok", 32'(u_if.data_data_ok), 32'd0);
        u_if.bus_data_ok = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // Round robin from last_src=INST: D,I,D,I, then 4 in-order responses.
        vecs.push_back(v(1,1,1,0,32'h0,        0,1,1,1,0));
        vecs.push_back(v(1,1,1,0,32'h0,        1,0,1,0,1));
        vecs.push_back(v(1,1,1,0,32'h0,        0,1,1,1,2));
        vecs.push_back(v(1,1,1,0,32'h0,        1,0,1,0,3));
        vecs.push_back(v(0,0,0,1,32'h1111_1111,0,0,0,0,4));
        vecs.push_back(v(0,0,0,1,32'h2222_2222,0,0,0,0,3));
        vecs.push_back(v(0,0,0,1,32'h3333_3333,0,0,0,0,2));
        vecs.push_back(v(0,0,0,1,32'h4444_4444,0,0,0,0,1));
        vecs.push_back(v(0,0,0,0,32'h0,        0,0,0,0,0));
        // Single load, response two cycles later.
        vecs.push_back(v(0,1,1,0,32'h0,        0,1,1,1,0));
        vecs.push_back(v(0,0,0,0,32'h0,        0,0,0,0,1));
        vecs.push_back(v(0,0,0,1,32'hDEAD_BEEF,0,0,0,0,1));
        vecs.push_back(v(0,0,0,0,32'h0,        0,0,0,0,0));
        // Fill to OT_DEPTH, full blocks grant, pop-only cycle, then grant.
        vecs.push_back(v(1,0,1,0,32'h0,        1,0,1,0,0));
        vecs.push_back(v(0,1,1,0,32'h0,        0,1,1,1,1));
        vecs.push_back(v(1,0,1,0,32'h0,        1,0,1,0,2));
        vecs.push_back(v(0,1,1,0,32'h0,        0,1,1,1,3));
        vecs.push_back(v(1,1,1,0,32'h0,        0,0,0,0,4));
        vecs.push_back(v(1,1,1,1,32'hA000_0001,0,0,0,0,4));
        vecs.push_back(v(1,1,1,0,32'h0,        1,0,1,0,3));
        vecs.push_back(v(0,0,0,1,32'hA000_0002,0,0,0,0,4));
        vecs.push_back(v(0,0,0,1,32'hA000_0003,0,0,0,0,3));
        vecs.push_back(v(0,0,0,1,32'hA000_0004,0,0,0,0,2));
        vecs.push_back(v(0,0,0,1,32'hA000_0005,0,0,0,0,1));
        vecs.push_back(v(0,0,0,0,32'h0,        0,0,0,0,0));
        // Response with empty FIFO -> ignored, sticky proto_err.
        vecs.push_back(v(0,0,0,1,32'hBAD0_0000,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,32'h0,        0,0,0,0,0));
        // LOCK_D holds bus while inst_req rises; then push+pop same cycle.
        vecs.push_back(v(0,1,0,0,32'h0,        0,0,1,1,0));
        vecs.push_back(v(1,1,0,0,32'h0,        0,0,1,1,0));
        vecs.push_back(v(1,1,0,0,32'h0,        0,0,1,1,0));
        vecs.push_back(v(1,1,1,0,32'h0,        0,1,1,1,0));
        vecs.push_back(v(1,0,1,1,32'hAAAA_0001,1,0,1,0,1));
        vecs.push_back(v(0,0,0,1,32'hBBBB_0002,0,0,0,0,1));
        vecs.push_back(v(0,0,0,0,32'h0,        0,0,0,0,0));
        // LOCK_I with inst_req withdrawn: no accept, back to IDLE.
        vecs.push_back(v(1,0,0,0,32'h0,        0,0,1,0,0));
        vecs.push_back(v(0,1,1,0,32'h0,        0,0,0,0,0));
        vecs.push_back(v(0,1,1,0,32'h0,        0,1,1,1,0));
        vecs.push_back(v(0,0,0,1,32'hCCCC_0003,0,0,0,0,1));
        vecs.push_back(v(0,0,0,0,32'h0,        0,0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) step(i, vecs[i]);

        // Async reset with 3 outstanding discards pending responses.
        step(100, v(0,1,1,0,32'h0, 0,1,1,1,0));
        step(101, v(0,1,1,0,32'h0, 0,1,1,1,1));
        step(102, v(0,1,1,0,32'h0, 0,1,1,1,2));
        @(negedge clk);
        u_if.data_req = 1'b0; u_if.bus_addr_ok = 1'b0;
        #1;
        chk("pre-reset ot_count", 32'(u_if.ot_count), 32'd3);
        #2 resetn = 1'b0;
        #1;
        $display("async reset: cnt=%0d perr=%0b", u_if.ot_count, u_if.proto_err);
        chk("async rst ot_count",  32'(u_if.ot_count),  32'd0);
        chk("async rst proto_err", 32'(u_if.proto_err), 32'd0);
        sb_q.delete();
        proto_model = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        step(103, v(0,0,0,1,32'h7777_7777, 0,0,0,0,0));
        step(104, v(0,0,0,0,32'h0,         0,0,0,0,0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
